// File: rtl/fft_pkg.sv
// Shared constants, sample layout and address helpers for the FFT output reorder path.
package fft_pkg;

   localparam int unsigned N     = 8;
   localparam int unsigned LOG2N = 3;
   localparam int unsigned DW    = 34;
   localparam int unsigned RE_W  = 17;
   localparam int unsigned IM_W  = 17;

   localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

   // One complex sample: real in the upper half, imaginary in the lower half.
   typedef struct packed {
      logic [RE_W-1:0] re;
      logic [IM_W-1:0] im;
   } sample_t;

   // Real field of a raw sample word.
   function automatic logic [RE_W-1:0] sample_re(input logic [DW-1:0] s);
      sample_t t;
      t = s;
      return t.re;
   endfunction

   // Imaginary field of a raw sample word.
   function automatic logic [IM_W-1:0] sample_im(input logic [DW-1:0] s);
      sample_t t;
      t = s;
      return t.im;
   endfunction

   // Mirror the bits of a bin index.
   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int i = 0; i < int'(LOG2N); i++) begin
         r[i] = a[int'(LOG2N) - 1 - i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two banks of N samples: synchronous write port, asynchronous read port.
module fft_pingpong_ram
   import fft_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic             wbank,
   input  logic [LOG2N-1:0] waddr,
   input  logic [DW-1:0]    wdata,
   input  logic             rbank,
   input  logic [LOG2N-1:0] raddr,
   output logic [DW-1:0]    rdata
);

   logic [DW-1:0] mem [2][N];

   // Capture one sample per accepted input beat; contents are not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wbank][waddr] <= wdata;
      end
   end

   // Read is a plain mux so the output sees the sample in the same cycle.
   assign rdata = mem[rbank][raddr];

endmodule

// File: rtl/fft_reorder.sv
// Converts bit-reversed FFT result frames into natural bin order via a ping-pong buffer.
module fft_reorder
   import fft_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          in_sop,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic          out_sop,
   output logic          out_eop,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic          frame_err
);

   logic             wbank;
   logic             rbank;
   logic [LOG2N-1:0] wcnt;
   logic [LOG2N-1:0] rcnt;
   logic [1:0]       full;
   logic             write_fire;
   logic             read_fire;
   logic             resync;
   logic [LOG2N-1:0] wr_addr;
   logic [DW-1:0]    rd_data;

   // Handshake and output decode, all from registered state.
   assign in_ready   = ~full[wbank];
   assign out_valid  = full[rbank];
   assign write_fire = in_valid & in_ready;
   assign read_fire  = out_valid & out_ready;
   assign resync     = write_fire & in_sop & (wcnt != '0);
   assign wr_addr    = resync ? '0 : bitrev(wcnt);
   assign out_sop    = out_valid & (rcnt == '0);
   assign out_eop    = out_valid & (rcnt == CNT_LAST);
   assign out_data   = out_valid ? rd_data : '0;

   fft_pingpong_ram u_ram (
      .clk   (clk),
      .we    (write_fire),
      .wbank (wbank),
      .waddr (wr_addr),
      .wdata (in_data),
      .rbank (rbank),
      .raddr (rcnt),
      .rdata (rd_data)
   );

   // Write/read counters, bank pointers, per-bank full flags and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbank     <= 1'b0;
         rbank     <= 1'b0;
         wcnt      <= '0;
         rcnt      <= '0;
         full      <= '0;
         frame_err <= 1'b0;
      end else begin
         if (write_fire) begin
            if (resync) begin
               wcnt      <= LOG2N'(1);
               frame_err <= 1'b1;
            end else if (wcnt == CNT_LAST) begin
               full[wbank] <= 1'b1;
               wbank       <= ~wbank;
               wcnt        <= '0;
            end else begin
               wcnt <= wcnt + LOG2N'(1);
            end
         end
         // A write only fires into a non-full bank and a read only from a full one,
         // so the two full-flag updates below never target the same bank.
         if (read_fire) begin
            if (rcnt == CNT_LAST) begin
               full[rbank] <= 1'b0;
               rbank       <= ~rbank;
               rcnt        <= '0;
            end else begin
               rcnt <= rcnt + LOG2N'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder: ordering, throughput, backpressure, resync and reset.
module tb_fft_reorder;

   localparam int unsigned DW = 34;
   localparam int unsigned N  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_sop;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic          out_sop;
   logic          out_eop;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          frame_err;

   int checks = 0;
   int errors = 0;

   // Natural output position j carries the sample that arrived as input beat brv[j].
   int brv [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   logic [DW-1:0] src_q [$];
   logic          sop_q [$];
   logic [DW-1:0] exp_q [$];

   always #5 clk = ~clk;

   fft_reorder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sop    (in_sop),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .out_data  (out_data),
      .out_ready (out_ready),
      .frame_err (frame_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Queue a frame: input beats in arrival order and/or the natural-order expectation.
   task automatic add_frame(input logic [DW-1:0] v [8], input bit to_src, input bit to_exp);
      for (int i = 0; i < 8; i++) begin
         if (to_src) begin
            src_q.push_back(v[i]);
            sop_q.push_back(i == 0);
         end
      end
      for (int j = 0; j < 8; j++) begin
         if (to_exp) exp_q.push_back(v[brv[j]]);
      end
   endtask

   task automatic add_seq(input int base, input bit to_src, input bit to_exp);
      logic [DW-1:0] v [8];
      for (int i = 0; i < 8; i++) v[i] = DW'(base + i);
      add_frame(v, to_src, to_exp);
   endtask

   // Drive src_q into the DUT; entered and left just after a rising edge.
   task automatic produce(input int valid_pct, input int budget, output int cyc);
      cyc = 0;
      while (src_q.size() > 0 && cyc < budget) begin
         in_valid = (int'($urandom_range(99)) < valid_pct);
         in_data  = src_q[0];
         in_sop   = sop_q[0];
         @(negedge clk);
         if (in_valid && in_ready) begin
            void'(src_q.pop_front());
            void'(sop_q.pop_front());
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_data  = '0;
      check("produce_left", 64'(src_q.size()), 64'(0));
   endtask

   // Drain exp_q.size() beats, comparing data and frame markers.
   task automatic consume(input int ready_pct, input int budget, input string tag, output int cyc);
      int got;
      int pos;
      int n;
      logic [DW-1:0] e;
      got = 0;
      pos = 0;
      n   = exp_q.size();
      cyc = 0;
      while (got < n && cyc < budget) begin
         out_ready = (int'($urandom_range(99)) < ready_pct);
         @(negedge clk);
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 64'(out_data), 64'(e));
            check({tag, "_sop_eop"}, {62'b0, out_sop, out_eop},
                  {62'b0, pos == 0, pos == int'(N) - 1});
            pos = (pos + 1) % int'(N);
            got++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0;
      check({tag, "_beats"}, 64'(got), 64'(n));
   endtask

   initial begin
      int pc;
      int cc;
      int acc;
      logic [DW-1:0] v [8];

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sop    = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset values
      #12;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_sop", 64'(out_sop), 64'(0));
      check("rst_out_eop", 64'(out_eop), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_frame_err", 64'(frame_err), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic reorder and one-cycle latency
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_sop   = (i == 0);
         in_data  = DW'(i);
         @(negedge clk);
         check("t1_no_early_valid", 64'(out_valid), 64'(0));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_sop   = 1'b0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         check("t1_valid", 64'(out_valid), 64'(1));
         check("t1_data", 64'(out_data), 64'(brv[j]));
         check("t1_sop_eop", {62'b0, out_sop, out_eop}, {62'b0, j == 0, j == 7});
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("t1_idle_after", 64'(out_valid), 64'(0));
      @(posedge clk); #1;

      // Back-to-back frames at full rate
      for (int k = 0; k < 4; k++) add_seq(8 * k, 1'b1, 1'b1);
      fork
         produce(100, 100, pc);
         consume(100, 100, "b2b", cc);
      join
      check("b2b_in_cycles", 64'(pc), 64'(32));
      check("b2b_out_cycles", 64'(cc), 64'(40));

      // Backpressure: both banks fill, output holds frame0 bin0
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 24; c++) begin
         in_valid = 1'b1;
         in_sop   = (acc % 8 == 0);
         in_data  = DW'(100 + acc);
         @(negedge clk);
         if (in_ready) acc++;
         if (out_valid) check("bp_hold_data", 64'(out_data), 64'(100));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_sop   = 1'b0;
      @(negedge clk);
      check("bp_accepted", 64'(acc), 64'(16));
      check("bp_in_ready_low", 64'(in_ready), 64'(0));
      check("bp_hold_sop", {62'b0, out_valid, out_sop}, {62'b0, 1'b1, 1'b1});
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         check("bp_f0_data", 64'(out_data), 64'(100 + brv[j]));
         check("bp_ready_during_drain", 64'(in_ready), 64'(0));
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      @(negedge clk);
      check("bp_ready_back", 64'(in_ready), 64'(1));
      check("bp_f1_bin0", 64'(out_data), 64'(108));
      @(posedge clk); #1;
      add_seq(108, 1'b0, 1'b1);
      add_seq(116, 1'b1, 1'b1);
      fork
         produce(100, 100, pc);
         consume(100, 200, "bp", cc);
      join
      @(negedge clk);
      check("bp_drained", {62'b0, out_valid, in_ready}, {62'b0, 1'b0, 1'b1});
      @(posedge clk); #1;

      // Random stalls on both sides, full-width signed samples
      for (int f = 0; f < 100; f++) begin
         for (int i = 0; i < 8; i++) v[i] = DW'({$urandom(), $urandom()});
         if (f == 0) begin
            v[0] = 34'h0_0003_FFFF;
            v[1] = 34'h3_FFFF_FFFF;
            v[2] = {17'h10000, 17'h1FFFF};
         end
         add_frame(v, 1'b1, 1'b1);
      end
      fork
         produce(50, 20000, pc);
         consume(50, 20000, "rnd", cc);
      join

      // Early sop abandons a partial frame
      @(negedge clk);
      check("es_err_before", 64'(frame_err), 64'(0));
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         src_q.push_back(DW'(200 + i));
         sop_q.push_back(i == 0);
      end
      add_seq(210, 1'b1, 1'b1);
      fork
         produce(100, 100, pc);
         consume(100, 100, "es", cc);
      join
      @(negedge clk);
      check("es_err_set", 64'(frame_err), 64'(1));
      check("es_no_extra_frame", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
      add_seq(220, 1'b1, 1'b1);
      fork
         produce(100, 100, pc);
         consume(100, 100, "es2", cc);
      join
      @(negedge clk);
      check("es_err_sticky", 64'(frame_err), 64'(1));
      @(posedge clk); #1;

      // Reset with one bank full and the other half written
      add_seq(300, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         src_q.push_back(DW'(400 + i));
         sop_q.push_back(i == 0);
      end
      produce(100, 100, pc);
      @(negedge clk);
      check("rm_pre_valid", 64'(out_valid), 64'(1));
      check("rm_pre_ready", 64'(in_ready), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      check("rm_in_ready", 64'(in_ready), 64'(1));
      check("rm_out_valid", 64'(out_valid), 64'(0));
      check("rm_out_sop_eop", {62'b0, out_sop, out_eop}, 64'(0));
      check("rm_out_data", 64'(out_data), 64'(0));
      check("rm_frame_err", 64'(frame_err), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      add_seq(500, 1'b1, 1'b1);
      fork
         produce(100, 100, pc);
         consume(100, 100, "rm", cc);
      join
      @(negedge clk);
      check("rm_idle_after", 64'(out_valid), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_reorder.md
Name: fft_reorder

Overview:
Output reorder buffer placed directly downstream of the fft core. It consumes the core's 34-bit serial result stream, which arrives in bit-reversed bin order. It emits the same frames in natural bin order (X0..XN-1) with valid/ready flow control. A two-bank ping-pong register buffer lets one frame be written while the previous frame is read out.

Parameters:
N, 8, FFT points per frame (power of 2)
LOG2N, 3, log2(N); width of address counters
DW, 34, sample width: [33:17] real, [16:0] imag, two's complement, passed through untouched

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  in_data holds a sample from the fft core
in_sop  input  1  first sample of a frame (bin 0 in bit-reversed order); qualified by in_valid
in_data  input  DW  sample from fft core
in_ready  output  1  buffer can accept in_data this cycle
out_valid  output  1  out_data holds a valid natural-order sample
out_sop  output  1  out_data is bin 0 of a frame
out_eop  output  1  out_data is bin N-1 of a frame
out_data  output  DW  reordered sample
out_ready  input  1  consumer accepts out_data this cycle
frame_err  output  1  sticky flag: a frame was truncated by an early in_sop

Behaviour:
- Reset (async, any time, including mid-frame): wbank=0, rbank=0, wcnt=0, rcnt=0, full[1:0]=0, frame_err=0.
- Reset output values: in_ready=1, out_valid=0, out_sop=0, out_eop=0, out_data=0.
- A buffered frame is discarded on reset.
- Write acceptance: write_fire = in_valid & in_ready. Define in_ready = ~full[wbank], decoded from registers only, with no combinational path from out_ready.
- On write_fire: mem[wbank][bitrev(wcnt)] <= in_data, and wcnt increments.
- When wcnt==N-1 on write_fire: full[wbank] <= 1, wbank toggles, wcnt <= 0.
- in_sop resync: if write_fire & in_sop & wcnt!=0, the partial frame is abandoned. The sample is written at address bitrev(0)=0, wcnt <= 1, frame_err <= 1 (sticky until rst). The bank is not marked full.
- in_sop with wcnt==0 is normal. in_sop is not required to start a frame: a frame is simply N consecutive accepted samples.
- Read side: out_valid = full[rbank]. out_data = mem[rbank][rcnt], read as a mux from registers with no extra pipeline stage. out_sop = out_valid & (rcnt==0). out_eop = out_valid & (rcnt==N-1).
- When out_valid=0, out_data is forced to 0.
- read_fire = out_valid & out_ready. On read_fire, rcnt increments. When rcnt==N-1: full[rbank] <= 0, rbank toggles, rcnt <= 0.
- Latency: the first natural-order sample is valid on the cycle after the edge that captures a frame's last write, i.e. 1 cycle after the last input beat.
- Throughput: sustained 1 sample/cycle with out_ready held high and no bubbles.
- Simultaneous events:
  - A frame completing into one bank and the drain of the other bank finishing in the same cycle both take effect. full bits are updated independently per bank.
  - If both banks are full, in_ready=0. When a drain frees a bank, in_ready rises the following cycle, not the same cycle.
- Hold rule: while out_valid=1 and out_ready=0, out_data, out_sop and out_eop hold stable. The bank being read is never written, because full[rbank] blocks writes to it.
- Overflow is impossible: upstream must honour in_ready. in_valid while in_ready=0 is ignored, with no write and no error.

Decomposition:
- Package fft_pkg: DW, N, LOG2N constants; sample real/imag field slices; function bitrev(LOG2N-bit).
- One sub-module, fft_pingpong_ram: 2xNxDW register array with one synchronous write port (bank, addr, data, we) and one asynchronous read port (bank, addr).
- Counters, full flags and the handshake stay in fft_reorder.

Test Plan:
- Basic reorder: reset, then feed one frame of in_data = 0..7 (in_sop on the first beat, out_ready=1).
  - out_data must be 0,4,2,6,1,5,3,7.
  - out_sop on the 0 beat, out_eop on the 7 beat, first out_valid 1 cycle after the last input.
- Back-to-back frames: feed 4 continuous frames of values 0..31 with no gaps and out_ready=1.
  - in_ready must stay 1 throughout.
  - Output must be 32 contiguous beats, frame k = 8k + {0,4,2,6,1,5,3,7}.
- Backpressure: out_ready=0 while 3 frames are offered.
  - in_ready must drop after 16 accepted samples, and out_data must stay fixed at frame0 bin0.
  - Release out_ready: in_ready must return 1 cycle after frame0's eop beat, with no sample lost or duplicated.
- Random stalls: randomise in_valid and out_ready at 50% over 100 frames.
  - The scoreboard must match bit-reversed reference ordering, including negative real/imag values such as 0x3FFFF.
- Early sop: send 5 samples, then a new frame starting with in_sop.
  - frame_err must rise, and the next output frame must be the new frame only.
  - frame_err must stay 1 until rst.
- Reset mid-operation: assert rst while bank0 is full and bank1 is half written.
  - All outputs must return to reset values asynchronously.
  - A subsequent clean frame must reorder correctly.
